// File: rtl/muxn_arb.sv
// Registered N-way channel multiplexer with direct-select or round-robin grant and valid/ready on both sides.
// Optional 32-bit accepted-transfer counter (port gcount) is built only when MUXN_GRANTCNT_EN is defined.
module muxn_arb #(
    parameter int N  = 64,
    parameter int CH = 8,
    parameter int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic [SW-1:0]   s,
    input  logic [CH*N-1:0] d,
    input  logic [CH-1:0]   dvalid,
    output logic [CH-1:0]   dready,
    output logic [N-1:0]    y,
    output logic            yvalid,
    input  logic            yready,
    output logic [SW-1:0]   ysel
`ifdef MUXN_GRANTCNT_EN
    ,
    output logic [31:0]     gcount
`endif
);

    logic [N-1:0]  ch_data [CH];

    logic [N-1:0]  y_q, y_d;
    logic [SW-1:0] ysel_q, ysel_d;
    logic          yvalid_q, yvalid_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load;
    logic          dir_ok;
    logic          rr_ok;
    logic [SW-1:0] rr_g;
    logic          grant_ok;
    logic [SW-1:0] grant_g;
    logic [N-1:0]  grant_data;
    logic          xfer;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_unpack
            assign ch_data[gi] = d[gi*N +: N];
        end
    endgenerate

    assign load = ~yvalid_q | yready;

    // Out-of-range selects never match any channel, so they yield no grant.
    always_comb begin
        dir_ok = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (s == SW'(k)) begin
                dir_ok = dvalid[k];
            end
        end
    end

    // Rotating scan starting at ptr; first valid channel wins.
    always_comb begin
        int idx;
        idx   = 0;
        rr_ok = 1'b0;
        rr_g  = '0;
        for (int i = 0; i < CH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= CH) begin
                idx = idx - CH;
            end
            if (!rr_ok && dvalid[idx]) begin
                rr_ok = 1'b1;
                rr_g  = SW'(idx);
            end
        end
    end

    always_comb begin
        if (mode) begin
            grant_ok = rr_ok;
            grant_g  = rr_g;
        end else begin
            grant_ok = dir_ok;
            grant_g  = s;
        end
    end

    always_comb begin
        dready = '0;
        if (!reset && load && grant_ok) begin
            for (int k = 0; k < CH; k++) begin
                dready[k] = (grant_g == SW'(k));
            end
        end
    end

    assign xfer = |(dvalid & dready);

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (grant_g == SW'(k)) begin
                grant_data = ch_data[k];
            end
        end
    end

    // A transfer wins over a drain, so drain+load in one cycle leaves no bubble.
    always_comb begin
        y_d      = y_q;
        ysel_d   = ysel_q;
        yvalid_d = yvalid_q;
        ptr_d    = ptr_q;
        if (xfer) begin
            y_d      = grant_data;
            ysel_d   = grant_g;
            yvalid_d = 1'b1;
            if (mode) begin
                ptr_d = (grant_g == SW'(CH - 1)) ? '0 : grant_g + 1'b1;
            end
        end else if (yready) begin
            yvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q      <= '0;
            ysel_q   <= '0;
            yvalid_q <= 1'b0;
            ptr_q    <= '0;
        end else begin
            y_q      <= y_d;
            ysel_q   <= ysel_d;
            yvalid_q <= yvalid_d;
            ptr_q    <= ptr_d;
        end
    end

    assign y      = y_q;
    assign ysel   = ysel_q;
    assign yvalid = yvalid_q;

`ifdef MUXN_GRANTCNT_EN
    logic [31:0] gcount_q, gcount_d;

    always_comb begin
        gcount_d = gcount_q;
        if (xfer) begin
            gcount_d = gcount_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gcount_q <= '0;
        end else begin
            gcount_q <= gcount_d;
        end
    end

    assign gcount = gcount_q;
`endif

endmodule

// File: tb/tb_muxn_arb.sv
// Self-checking bench for muxn_arb: 8-channel table run with scoreboard, plus 5-channel boundary,
// reset and (when MUXN_GRANTCNT_EN is defined) counter sequences.
module tb_muxn_arb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 8-channel, 64-bit instance
    logic         mode8;
    logic [2:0]   s8;
    logic [511:0] d8;
    logic [7:0]   dvalid8, dready8;
    logic [63:0]  y8;
    logic         yvalid8, yready8;
    logic [2:0]   ysel8;
`ifdef MUXN_GRANTCNT_EN
    logic [31:0]  gcount8, gcount5;
`endif

    // 5-channel, 16-bit instance
    logic         mode5;
    logic [2:0]   s5;
    logic [79:0]  d5;
    logic [4:0]   dvalid5, dready5;
    logic [15:0]  y5;
    logic         yvalid5, yready5;
    logic [2:0]   ysel5;

    muxn_arb dut8 (
        .clk(clk), .reset(reset), .mode(mode8), .s(s8), .d(d8),
        .dvalid(dvalid8), .dready(dready8), .y(y8), .yvalid(yvalid8),
        .yready(yready8), .ysel(ysel8)
`ifdef MUXN_GRANTCNT_EN
        , .gcount(gcount8)
`endif
    );

    muxn_arb #(.N(16), .CH(5)) dut5 (
        .clk(clk), .reset(reset), .mode(mode5), .s(s5), .d(d5),
        .dvalid(dvalid5), .dready(dready5), .y(y5), .yvalid(yvalid5),
        .yready(yready5), .ysel(ysel5)
`ifdef MUXN_GRANTCNT_EN
        , .gcount(gcount5)
`endif
    );

    typedef struct {
        logic       mode;
        logic [2:0] s;
        logic [7:0] dvalid;
        logic       yready;
        logic [7:0] exp_dready;
        logic       exp_xfer;
        logic [2:0] exp_g;
        logic       exp_yvalid;
    } vec_t;

    typedef struct {
        logic [63:0] y;
        logic [2:0]  sel;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic [2:0] sv, input logic [7:0] dv,
                                input logic yr, input logic [7:0] edr, input logic ex,
                                input logic [2:0] eg, input logic eyv);
        vec_t v;
        v.mode = m; v.s = sv; v.dvalid = dv; v.yready = yr;
        v.exp_dready = edr; v.exp_xfer = ex; v.exp_g = eg; v.exp_yvalid = eyv;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        exp_t e;
        exp_t last;
        int   pat [3];
        pat = '{2, 5, 7};
        last.y = '0;
        last.sel = '0;

        // Stimulus table for the 8-channel instance (starts with ptr=0, output empty)
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b0, 3'(i), 8'hFF, 1'b1, 8'(1) << i, 1'b1, 3'(i), 1'b1));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1'b1, 3'd0, 8'hFF, 1'b1, 8'(1) << (i % 8), 1'b1, 3'(i % 8), 1'b1));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1'b1, 3'd0, 8'hA4, 1'b1, 8'(1) << pat[i % 3], 1'b1, 3'(pat[i % 3]), 1'b1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1));
        vecs.push_back(mk(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 1'b1));
        vecs.push_back(mk(1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0));
        vecs.push_back(mk(1'b1, 3'd0, 8'hFF, 1'b0, 8'h02, 1'b1, 3'd1, 1'b1));
        vecs.push_back(mk(1'b0, 3'd3, 8'hF7, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0));
        vecs.push_back(mk(1'b0, 3'd4, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd4, 1'b1));
        vecs.push_back(mk(1'b0, 3'd5, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1));

        for (int k = 0; k < 8; k++) d8[k*64 +: 64] = 64'(k + 100);
        for (int k = 0; k < 5; k++) d5[k*16 +: 16] = 16'(k + 200);
        mode8 = 1'b1; s8 = '0; dvalid8 = 8'hFF; yready8 = 1'b1;
        mode5 = 1'b1; s5 = '0; dvalid5 = 5'h1F; yready5 = 1'b1;

        // Reset: no grant while asserted, outputs cleared
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_dready8", 64'(dready8), 64'h0);
        chk("reset_dready5", 64'(dready5), 64'h0);
        @(posedge clk); #1;
        chk("reset_yvalid8", 64'(yvalid8), 64'h0);
        chk("reset_y8", y8, 64'h0);
        chk("reset_ysel8", 64'(ysel8), 64'h0);
        chk("reset_yvalid5", 64'(yvalid5), 64'h0);
        dvalid5 = '0;

        foreach (vecs[i]) begin
            @(negedge clk);
            reset   = 1'b0;
            mode8   = vecs[i].mode;
            s8      = vecs[i].s;
            dvalid8 = vecs[i].dvalid;
            yready8 = vecs[i].yready;
            if (vecs[i].exp_xfer) begin
                e.y   = 64'(100 + int'(vecs[i].exp_g));
                e.sel = vecs[i].exp_g;
                sb.push_back(e);
            end
            #1;
            chk("dready", 64'(dready8), 64'(vecs[i].exp_dready));
            @(posedge clk); #1;
            chk("yvalid", 64'(yvalid8), 64'(vecs[i].exp_yvalid));
            if (vecs[i].exp_xfer) begin
                last = sb.pop_front();
                chk("y_new", y8, last.y);
                chk("ysel_new", 64'(ysel8), 64'(last.sel));
            end else if (vecs[i].exp_yvalid) begin
                chk("y_hold", y8, last.y);
                chk("ysel_hold", 64'(ysel8), 64'(last.sel));
            end
            $display("vec %0d mode=%0d s=%0d dvalid=%h yready=%0d -> dready=%h yvalid=%0d ysel=%0d y=%0d",
                     i, mode8, s8, dvalid8, yready8, dready8, yvalid8, ysel8, y8);
        end

        // Reset mid-stream: pointer sits at 2 before reset, must restart at 0
        @(negedge clk);
        mode8 = 1'b1; dvalid8 = 8'hFF; yready8 = 1'b1;
        #1;
        chk("pre_reset_dready", 64'(dready8), 64'h04);
        @(posedge clk); #1;
        chk("pre_reset_ysel", 64'(ysel8), 64'd2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_dready", 64'(dready8), 64'h0);
        @(posedge clk); #1;
        chk("midreset_yvalid", 64'(yvalid8), 64'h0);
        chk("midreset_y", y8, 64'h0);
        chk("midreset_ysel", 64'(ysel8), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_dready", 64'(dready8), 64'h01);
        @(posedge clk); #1;
        chk("post_reset_ysel", 64'(ysel8), 64'd0);
        chk("post_reset_y", y8, 64'd100);
        $display("reset mid-stream: first grant ysel=%0d y=%0d", ysel8, y8);

`ifdef MUXN_GRANTCNT_EN
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("gcount_reset", 64'(gcount8), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 18; i++) begin
            yready8 = (i >= 10 && i < 13) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
        end
        chk("gcount_15", 64'(gcount8), 64'd15);
        dut8.gcount_q = 32'hFFFF_FFFF;
        yready8 = 1'b1;
        @(posedge clk); #1;
        chk("gcount_wrap", 64'(gcount8), 64'h0);
        $display("counter: gcount=%0d after wrap", gcount8);
`endif

        // 5-channel boundary sequence
        @(negedge clk);
        reset = 1'b0;
        mode5 = 1'b0; s5 = 3'd1; dvalid5 = 5'h1F; yready5 = 1'b1;
        #1;
        chk("ch5_dready_s1", 64'(dready5), 64'h02);
        @(posedge clk); #1;
        chk("ch5_y_s1", 64'(y5), 64'd201);
        chk("ch5_ysel_s1", 64'(ysel5), 64'd1);
        @(negedge clk);
        s5 = 3'd6;
        #1;
        chk("ch5_dready_s6", 64'(dready5), 64'h0);
        @(posedge clk); #1;
        chk("ch5_yvalid_drain", 64'(yvalid5), 64'h0);
        @(negedge clk);
        s5 = 3'd5;
        #1;
        chk("ch5_dready_s5", 64'(dready5), 64'h0);
        @(posedge clk); #1;
        chk("ch5_yvalid_s5", 64'(yvalid5), 64'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mode5 = 1'b1; dvalid5 = 5'b10000;
            #1;
            chk("ch5_rr4_dready", 64'(dready5), 64'h10);
            @(posedge clk); #1;
            chk("ch5_rr4_ysel", 64'(ysel5), 64'd4);
            chk("ch5_rr4_y", 64'(y5), 64'd204);
            $display("ch5 rr grant %0d: ysel=%0d y=%0d", i, ysel5, y5);
        end
        @(negedge clk);
        dvalid5 = 5'h1F;
        #1;
        chk("ch5_wrap_dready", 64'(dready5), 64'h01);
        @(posedge clk); #1;
        chk("ch5_wrap_ysel", 64'(ysel5), 64'd0);
        chk("ch5_wrap_y", 64'(y5), 64'd200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
